periph_bus_arb: RTL and testbench

//  Shares one peripheral register port (gpio-style: wr_en/addr/wdata in, combinational rdata out) between
//  two requesters: m0 = core LSU, m1 = debug/DMA. Round-robin arbitration, one latched transaction at a time,
//  req/ack handshake, optional bounded lock so a master can do read-modify-write sequences.

---
 rtl/periph_bus_arb.sv | 132 +++++++++++++
 tb/tb_periph_bus_arb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_arb.sv
// Round-robin arbiter sharing one combinational peripheral register port between two requesters,
// with a one-transaction-at-a-time req/ack handshake and a bounded lock for read-modify-write chains.
module periph_bus_arb #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic              m0_lock_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic              m1_lock_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic [DATA_W-1:0] rdata_i
);

  localparam int CNT_W = $clog2(LOCK_MAX) + 1;
  localparam logic [CNT_W-1:0] CHAIN_LAST = CNT_W'(LOCK_MAX - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_nxt;
  logic              last_grant, last_grant_nxt;  // 0 = m0, 1 = m1
  logic              owner, owner_nxt;
  logic              cmd_we, cmd_we_nxt;
  logic [ADDR_W-1:0] cmd_addr, cmd_addr_nxt;
  logic [DATA_W-1:0] cmd_wdata, cmd_wdata_nxt;
  logic [CNT_W-1:0]  lock_cnt, lock_cnt_nxt;
  logic              latch_cmd;
  logic              sel;
  logic              owner_req, owner_lock;

  assign owner_req  = owner ? m1_req_i  : m0_req_i;
  assign owner_lock = owner ? m1_lock_i : m0_lock_i;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    state_nxt      = state;
    last_grant_nxt = last_grant;
    owner_nxt      = owner;
    lock_cnt_nxt   = lock_cnt;
    cmd_we_nxt     = cmd_we;
    cmd_addr_nxt   = cmd_addr;
    cmd_wdata_nxt  = cmd_wdata;
    latch_cmd      = 1'b0;
    sel            = owner;

    case (state)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          // On a tie the master that did not win last time gets the port.
          sel            = (m0_req_i && m1_req_i) ? ~last_grant : ~m0_req_i;
          latch_cmd      = 1'b1;
          owner_nxt      = sel;
          last_grant_nxt = sel;
          state_nxt      = ACCESS;
        end
      end
      ACCESS: state_nxt = DONE;
      DONE: begin
        if (owner_lock && owner_req && (lock_cnt < CHAIN_LAST)) begin
          lock_cnt_nxt = lock_cnt + CNT_W'(1);
          latch_cmd    = 1'b1;
          state_nxt    = ACCESS;
        end else begin
          lock_cnt_nxt = '0;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (latch_cmd) begin
      cmd_we_nxt    = sel ? m1_we_i    : m0_we_i;
      cmd_addr_nxt  = sel ? m1_addr_i  : m0_addr_i;
      cmd_wdata_nxt = sel ? m1_wdata_i : m0_wdata_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      lock_cnt   <= '0;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      owner      <= owner_nxt;
      lock_cnt   <= lock_cnt_nxt;
      cmd_we     <= cmd_we_nxt;
      cmd_addr   <= cmd_addr_nxt;
      cmd_wdata  <= cmd_wdata_nxt;
    end
  end

  // Read data is captured at the end of the access cycle and held until the owner's next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rdata_o <= '0;
      m1_rdata_o <= '0;
    end else if (state == ACCESS && !cmd_we) begin
      if (owner) m1_rdata_o <= rdata_i;
      else       m0_rdata_o <= rdata_i;
    end
  end

  // Decoded straight from the state register so reset drops them without waiting for an edge.
  assign wr_en_o  = (state == ACCESS) && cmd_we;
  assign m0_ack_o = (state == DONE) && !owner;
  assign m1_ack_o = (state == DONE) && owner;
  assign addr_o   = cmd_addr;
  assign wdata_o  = cmd_wdata;

endmodule

// File: tb/tb_periph_bus_arb.sv
// Self-checking bench for periph_bus_arb: directed scenarios plus random traffic, all compared
// every cycle against a transaction-scheduling reference model.
module tb_periph_bus_arb;

  localparam int LOCK_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req [2];
  logic        we [2];
  logic        lock [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        m0_ack, m1_ack, wr_en;
  logic [31:0] m0_rdata, m1_rdata, addr_o, wdata_o, rdata;

  periph_bus_arb #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_lock_i(lock[0]), .m0_addr_i(addr[0]),
    .m0_wdata_i(wdata[0]), .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
    .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_lock_i(lock[1]), .m1_addr_i(addr[1]),
    .m1_wdata_i(wdata[1]), .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
    .wr_en_o(wr_en), .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata)
  );

  always #5 clk = ~clk;

  // Peripheral: four registers decoded on addr[3:2], combinational read.
  logic [31:0] mem [4] = '{default: 32'h0};
  assign rdata = mem[addr_o[3:2]];
  always @(posedge clk) if (wr_en) mem[addr_o[3:2]] <= wdata_o;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: schedules whole transactions by cycle number.
  int          k;            // edges since reset release
  bit          active;       // a granted transaction is in flight
  bit          own, last;
  int          acc_cyc;      // cycle in which the current access is on the port
  int          chain_n;
  bit          m_we;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] exp_rdata [2];
  logic [31:0] mem_m [4] = '{default: 32'h0};
  bit          exp_wr, exp_ack0, exp_ack1;
  int          ackq [$];

  task automatic model_reset();
    active = 0; last = 1; own = 0; chain_n = 0; acc_cyc = -10; k = 0;
    m_we = 0; m_addr = 0; m_wdata = 0;
    exp_rdata[0] = 0; exp_rdata[1] = 0;
    exp_wr = 0; exp_ack0 = 0; exp_ack1 = 0;
  endtask

  task automatic take_cmd(input bit m);
    m_we = we[m]; m_addr = addr[m]; m_wdata = wdata[m];
  endtask

  task automatic model_step();
    if (active && k == acc_cyc + 1) begin
      if (m_we) mem_m[m_addr[3:2]] = m_wdata;
      else      exp_rdata[own] = mem_m[m_addr[3:2]];
    end else if (active && k == acc_cyc + 2) begin
      if (lock[own] && req[own] && chain_n < LOCK_MAX - 1) begin
        chain_n++; acc_cyc = k; take_cmd(own);
      end else begin
        active = 0; chain_n = 0;
      end
    end else if (!active && (req[0] || req[1])) begin
      own = (req[0] && req[1]) ? !last : !req[0];
      last = own; active = 1; acc_cyc = k; chain_n = 0;
      take_cmd(own);
    end
    exp_wr   = active && acc_cyc == k && m_we;
    exp_ack0 = active && k == acc_cyc + 1 && own == 0;
    exp_ack1 = active && k == acc_cyc + 1 && own == 1;
  endtask

  task automatic compare_all();
    check("wr_en", wr_en, exp_wr);
    check("m0_ack", m0_ack, exp_ack0);
    check("m1_ack", m1_ack, exp_ack1);
    check("m0_rdata", m0_rdata, exp_rdata[0]);
    check("m1_rdata", m1_rdata, exp_rdata[1]);
    check("addr_o", addr_o, m_addr);
    check("wdata_o", wdata_o, m_wdata);
  endtask

  task automatic tick();
    @(posedge clk);
    k++;
    model_step();
    #1;
    compare_all();
    if (m0_ack) ackq.push_back(0);
    if (m1_ack) ackq.push_back(1);
  endtask

  task automatic drive(input bit m, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit l);
    req[m] = 1; we[m] = w; addr[m] = a; wdata[m] = d; lock[m] = l;
  endtask

  task automatic new_cmd(input bit m);
    drive(m, 1'($urandom_range(0, 1)), {28'h0, 2'($urandom_range(0, 3)), 2'b00}, $urandom,
          ($urandom_range(0, 1) == 1));
  endtask

  int cnt;

  initial begin
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; we[i] = 0; lock[i] = 0; addr[i] = 0; wdata[i] = 0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1;

    // Single m0 write: one write cycle, ack the following cycle.
    drive(0, 1, 32'h4, 32'hA5, 0);
    tick();
    check("t1_wr_en", wr_en, 1'b1);
    check("t1_addr", addr_o, 32'h4);
    check("t1_wdata", wdata_o, 32'hA5);
    tick();
    check("t1_ack", m0_ack, 1'b1);
    check("t1_wr_after", wr_en, 1'b0);
    req[0] = 0;
    tick();

    // ctrl register at 0 set to 8, then m1 reads it.
    drive(0, 1, 32'h0, 32'h8, 0);
    tick(); tick();
    req[0] = 0;
    tick();
    drive(1, 0, 32'h0, 32'h0, 0);
    tick(); tick();
    check("t2_ack", m1_ack, 1'b1);
    check("t2_m1_rdata", m1_rdata, 32'h8);
    check("t2_m0_rdata", m0_rdata, 32'h0);
    req[1] = 0;
    tick();

    // Both request continuously: strict alternation starting with m0.
    ackq.delete();
    drive(0, 0, 32'h4, 32'h0, 0);
    drive(1, 0, 32'h8, 32'h0, 0);
    repeat (12) tick();
    req[0] = 0; req[1] = 0;
    check("t3_ack_count", ackq.size(), 4);
    for (int i = 0; i < ackq.size(); i++) check($sformatf("t3_order%0d", i), ackq[i], i % 2);
    repeat (2) tick();

    // m0 holds lock: exactly LOCK_MAX chained m0 transactions, then m1.
    ackq.delete();
    drive(0, 1, 32'hC, 32'h1234, 1);
    drive(1, 0, 32'hC, 32'h0, 0);
    repeat (12) tick();
    req[0] = 0; req[1] = 0; lock[0] = 0;
    cnt = 0;
    while (cnt < ackq.size() && ackq[cnt] == 0) cnt++;
    check("t4_m0_chain", cnt, LOCK_MAX);
    check("t4_m1_next", (cnt < ackq.size()) ? 1 : 0, 1);
    repeat (2) tick();

    // m1 drops req during its access: still one ack, no further access.
    ackq.delete();
    drive(1, 0, 32'h8, 32'h0, 0);
    tick();
    req[1] = 0;
    repeat (4) tick();
    check("t6_ack_count", ackq.size(), 1);

    // Reset in the middle of a write access.
    drive(0, 1, 32'hC, 32'h55, 0);
    tick();
    check("t5_wr_before", wr_en, 1'b1);
    rst_n = 0;
    #1;
    model_reset();
    check("t5_wr_reset", wr_en, 1'b0);
    check("t5_ack0_reset", m0_ack, 1'b0);
    check("t5_ack1_reset", m1_ack, 1'b0);
    drive(0, 0, 32'hC, 32'h0, 0);
    drive(1, 0, 32'h4, 32'h0, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    ackq.delete();
    repeat (3) tick();
    check("t5_tie_m0", (ackq.size() > 0) ? ackq[0] : 9, 0);
    req[0] = 0; req[1] = 0;
    repeat (2) tick();

    // Random traffic obeying the handshake.
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m]) begin
          if ($urandom_range(0, 2) == 0) new_cmd(1'(m));
        end else if ((m == 0) ? m0_ack : m1_ack) begin
          if ($urandom_range(0, 3) == 0) new_cmd(1'(m));
          else req[m] = 0;
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
